ddr_burst_arbiter: RTL and testbench

- Shares the single DDR burst port between NUM_REQ requesters, such as the instruction fetch, data load/store and input-loader paths of the AP.
- Uses round-robin arbitration at burst granularity.
- Issues exactly one burst command per grant and holds the grant until the controller reports burst_finish.
- Routes write-data requests and read-data-valid strobes only to the granted requester.
- Guards the controller against zero-length bursts and flags hung bursts.

---
 rtl/ddr_burst_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
//   Shares one DDR burst port between NUM_REQ requesters. Round-robin
//   arbitration at burst granularity, one controller command per grant, and
//   the grant is held until the controller reports the burst finished.
//   A zero-length burst completes without reaching the controller, and a
//   burst that does not finish within TIMEOUT cycles sets a sticky error.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_rd / req_wr          per-requester read / write burst requests (level)
//   req_*_addr, req_*_len    packed per-requester burst address / length
//   req_wr_data              packed per-requester write data
//   grant                    one-hot current owner
//   req_wr_data_req          write-data pop strobe, owner only
//   req_rd_data              read data, broadcast
//   req_rd_data_valid        read-data strobe, owner only
//   req_done                 one-cycle completion pulse to the owner
//   mem_*                    DDR controller burst interface
//   init_calib_complete      DDR calibration done; gates arbitration
//   timeout_err              sticky hung-burst flag
module ddr_burst_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int DDR_DATA_WIDTH = 128,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int TIMEOUT        = 4096
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_rd,
   input  logic [NUM_REQ-1:0]                 req_wr,
   input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]  req_rd_addr,
   input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0]  req_wr_addr,
   input  logic [NUM_REQ*10-1:0]              req_rd_len,
   input  logic [NUM_REQ*10-1:0]              req_wr_len,
   input  logic [NUM_REQ*DDR_DATA_WIDTH-1:0]  req_wr_data,
   output logic [NUM_REQ-1:0]                 grant,
   output logic [NUM_REQ-1:0]                 req_wr_data_req,
   output logic [DDR_DATA_WIDTH-1:0]          req_rd_data,
   output logic [NUM_REQ-1:0]                 req_rd_data_valid,
   output logic [NUM_REQ-1:0]                 req_done,
   output logic                               mem_rd_burst_req,
   output logic                               mem_wr_burst_req,
   output logic [DDR_ADDR_WIDTH-1:0]          mem_rd_burst_addr,
   output logic [DDR_ADDR_WIDTH-1:0]          mem_wr_burst_addr,
   output logic [9:0]                         mem_rd_burst_len,
   output logic [9:0]                         mem_wr_burst_len,
   output logic [DDR_DATA_WIDTH-1:0]          mem_wr_burst_data,
   input  logic                               mem_wr_burst_data_req,
   input  logic [DDR_DATA_WIDTH-1:0]          mem_rd_burst_data,
   input  logic                               mem_rd_burst_data_valid,
   input  logic                               mem_burst_finish,
   input  logic                               init_calib_complete,
   output logic                               timeout_err
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   state_t                    state, state_nxt;
   logic [PW-1:0]             rr_ptr;
   logic [TW-1:0]             timer;
   logic                      dir_rd;
   logic [DDR_ADDR_WIDTH-1:0] addr_q;
   logic [9:0]                len_q;

   logic                      win_valid;
   logic [PW-1:0]             win_idx;
   logic                      win_rd;
   logic [DDR_ADDR_WIDTH-1:0] win_addr;
   logic [9:0]                win_len;
   logic [PW:0]               cand;
   logic                      arb_go;
   logic                      timer_exp;

   // Round-robin search starting at rr_ptr; candidate index wraps modulo NUM_REQ.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_REQ))
            cand = cand - (PW+1)'(NUM_REQ);
         if (!win_valid && (req_rd[cand[PW-1:0]] || req_wr[cand[PW-1:0]])) begin
            win_valid = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
      // Read takes priority when the winner requests both directions.
      win_rd   = req_rd[win_idx];
      win_addr = win_rd ? req_rd_addr[win_idx*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH]
                        : req_wr_addr[win_idx*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
      win_len  = win_rd ? req_rd_len[win_idx*10 +: 10]
                        : req_wr_len[win_idx*10 +: 10];
   end

   assign arb_go    = init_calib_complete && win_valid;
   assign timer_exp = (timer == TW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_go) state_nxt = (win_len == '0) ? DONE : ISSUE;
         ISSUE:   state_nxt = BUSY;
         BUSY:    if (mem_burst_finish || timer_exp) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         timer       <= '0;
         grant       <= '0;
         dir_rd      <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (arb_go) begin
                  grant  <= NUM_REQ'(1) << win_idx;
                  rr_ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                  dir_rd <= win_rd;
                  addr_q <= win_addr;
                  len_q  <= win_len;
               end
            end
            ISSUE: timer <= '0;
            BUSY: begin
               timer <= timer + 1'b1;
               if (timer_exp) timeout_err <= 1'b1;
            end
            DONE: grant <= '0;
            default: ;
         endcase
      end
   end

   // Owner data mux: grant is one-hot, so an AND-OR tree is sufficient.
   always_comb begin
      mem_wr_burst_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (grant[i]) mem_wr_burst_data = mem_wr_burst_data | req_wr_data[i*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
   end

   assign mem_rd_burst_req  = (state == ISSUE) &&  dir_rd;
   assign mem_wr_burst_req  = (state == ISSUE) && !dir_rd;
   assign mem_rd_burst_addr = addr_q;
   assign mem_wr_burst_addr = addr_q;
   assign mem_rd_burst_len  = len_q;
   assign mem_wr_burst_len  = len_q;

   // Controller strobes only reach the owner, and only while a burst is in flight.
   assign req_wr_data_req   = (state == BUSY && mem_wr_burst_data_req)   ? grant : '0;
   assign req_rd_data_valid = (state == BUSY && mem_rd_burst_data_valid) ? grant : '0;
   assign req_rd_data       = (state == BUSY) ? mem_rd_burst_data : '0;
   assign req_done          = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter
//   Scoreboard bench for ddr_burst_arbiter: expected commands and completions
//   are queued as requests are driven and compared as the DUT produces them.
//   A small controller model answers each command with len data strobes and
//   a finish pulse, or stays silent while ctl_hang is set.
module tb_ddr_burst_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 28;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_rd, req_wr;
   logic [N*AW-1:0] req_rd_addr, req_wr_addr;
   logic [N*10-1:0] req_rd_len, req_wr_len;
   logic [N*DW-1:0] req_wr_data;
   logic [N-1:0]    grant, req_wr_data_req, req_rd_data_valid, req_done;
   logic [DW-1:0]   req_rd_data;
   logic            mem_rd_burst_req, mem_wr_burst_req;
   logic [AW-1:0]   mem_rd_burst_addr, mem_wr_burst_addr;
   logic [9:0]      mem_rd_burst_len, mem_wr_burst_len;
   logic [DW-1:0]   mem_wr_burst_data;
   logic            mem_wr_burst_data_req;
   logic [DW-1:0]   mem_rd_burst_data;
   logic            mem_rd_burst_data_valid;
   logic            mem_burst_finish;
   logic            init_calib_complete;
   logic            timeout_err;

   ddr_burst_arbiter #(
      .NUM_REQ(N), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_rd(req_rd), .req_wr(req_wr),
      .req_rd_addr(req_rd_addr), .req_wr_addr(req_wr_addr),
      .req_rd_len(req_rd_len), .req_wr_len(req_wr_len),
      .req_wr_data(req_wr_data),
      .grant(grant), .req_wr_data_req(req_wr_data_req),
      .req_rd_data(req_rd_data), .req_rd_data_valid(req_rd_data_valid),
      .req_done(req_done),
      .mem_rd_burst_req(mem_rd_burst_req), .mem_wr_burst_req(mem_wr_burst_req),
      .mem_rd_burst_addr(mem_rd_burst_addr), .mem_wr_burst_addr(mem_wr_burst_addr),
      .mem_rd_burst_len(mem_rd_burst_len), .mem_wr_burst_len(mem_wr_burst_len),
      .mem_wr_burst_data(mem_wr_burst_data),
      .mem_wr_burst_data_req(mem_wr_burst_data_req),
      .mem_rd_burst_data(mem_rd_burst_data),
      .mem_rd_burst_data_valid(mem_rd_burst_data_valid),
      .mem_burst_finish(mem_burst_finish),
      .init_calib_complete(init_calib_complete),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit [AW-1:0] addr;
      bit [9:0]    len;
      int          owner;
   } cmd_t;

   typedef struct {
      int owner;
      int beats;
   } done_t;

   cmd_t  exp_q[$];
   done_t done_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cmd_cnt = 0, done_cnt = 0;
   int last_cmd_cyc = 0, last_done_cyc = 0;
   int err_cyc = -1;
   bit err_seen = 1'b0;
   int beats = 0;
   int cur_owner = 0;
   bit ctl_hang = 1'b0;
   bit stray_go = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   function automatic logic [DW-1:0] wd(input int i);
      return 32'hC0DE_0000 | DW'(i);
   endfunction

   task automatic set_rd(input int i, input logic [AW-1:0] a, input logic [9:0] l);
      req_rd_addr[i*AW +: AW] = a;
      req_rd_len[i*10 +: 10]  = l;
   endtask

   task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [9:0] l);
      req_wr_addr[i*AW +: AW] = a;
      req_wr_len[i*10 +: 10]  = l;
   endtask

   // A completed burst yields len strobes; a hung one yields none.
   task automatic expect_burst(input bit rd, input int owner, input logic [AW-1:0] a,
                               input logic [9:0] l, input int nbeats);
      if (l != 0) exp_q.push_back('{rd, a, l, owner});
      done_q.push_back('{owner, nbeats});
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_cnt < target && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      if (done_cnt < target) check("wait_done", 128'(done_cnt), 128'(target));
   endtask

   task automatic wait_cmd(input int target);
      int k = 0;
      while (cmd_cnt < target && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      if (cmd_cnt < target) check("wait_cmd", 128'(cmd_cnt), 128'(target));
   endtask

   task automatic do_reset();
      req_rd = '0;
      req_wr = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {grant, req_done, req_rd_data_valid, req_wr_data_req,
                         mem_rd_burst_req, mem_wr_burst_req, timeout_err}, '0);
      check("rst_cmd_fields", {mem_rd_burst_addr, mem_rd_burst_len,
                               mem_wr_burst_addr, mem_wr_burst_len}, '0);
      #1 rst = 1'b0;
   endtask

   // Controller model: acts one delta after each rising edge.
   initial begin
      bit rd;
      int n;
      mem_wr_burst_data_req   = 1'b0;
      mem_rd_burst_data       = '0;
      mem_rd_burst_data_valid = 1'b0;
      mem_burst_finish        = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stray_go) begin
            mem_burst_finish = 1'b1; mem_rd_burst_data_valid = 1'b1; mem_wr_burst_data_req = 1'b1;
            @(posedge clk); #1;
            mem_burst_finish = 1'b0; mem_rd_burst_data_valid = 1'b0; mem_wr_burst_data_req = 1'b0;
         end else if (!rst && !ctl_hang && (mem_rd_burst_req || mem_wr_burst_req)) begin
            rd = mem_rd_burst_req;
            n  = rd ? int'(mem_rd_burst_len) : int'(mem_wr_burst_len);
            for (int b = 0; b < n; b++) begin
               @(posedge clk); #1;
               if (rd) begin
                  mem_rd_burst_data_valid = 1'b1;
                  mem_rd_burst_data = 32'h5A00_0000 + 32'(b);
               end else begin
                  mem_wr_burst_data_req = 1'b1;
               end
            end
            @(posedge clk); #1;
            mem_rd_burst_data_valid = 1'b0;
            mem_wr_burst_data_req   = 1'b0;
            mem_burst_finish        = 1'b1;
            @(posedge clk); #1;
            mem_burst_finish = 1'b0;
         end
      end
   end

   // Monitor: compares DUT activity against the scoreboard queues.
   always @(negedge clk) begin
      cmd_t  c;
      done_t d;
      if (rst) begin
         beats    = 0;
         err_seen = 1'b0;
      end else begin
         if (timeout_err && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
         end
         if (mem_rd_burst_req || mem_wr_burst_req) begin
            cmd_cnt++;
            last_cmd_cyc = cyc;
            beats = 0;
            if (exp_q.size() == 0) begin
               check("cmd_unexpected", 1, 0);
            end else begin
               c = exp_q.pop_front();
               check("cmd_single", 128'(mem_rd_burst_req & mem_wr_burst_req), 0);
               check("cmd_dir", 128'(mem_rd_burst_req), 128'(c.rd));
               check("cmd_addr", c.rd ? 128'(mem_rd_burst_addr) : 128'(mem_wr_burst_addr), 128'(c.addr));
               check("cmd_len", c.rd ? 128'(mem_rd_burst_len) : 128'(mem_wr_burst_len), 128'(c.len));
               check("cmd_grant", 128'(grant), 128'(oh(c.owner)));
               cur_owner = c.owner;
            end
         end
         if (|req_rd_data_valid) begin
            beats++;
            check("rd_valid_owner", 128'(req_rd_data_valid), 128'(oh(cur_owner)));
            check("rd_data", 128'(req_rd_data), 128'(mem_rd_burst_data));
         end
         if (|req_wr_data_req) begin
            beats++;
            check("wr_req_owner", 128'(req_wr_data_req), 128'(oh(cur_owner)));
            check("wr_data", 128'(mem_wr_burst_data), 128'(wd(cur_owner)));
         end
         if (|req_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (done_q.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               d = done_q.pop_front();
               check("done_owner", 128'(req_done), 128'(oh(d.owner)));
               check("done_beats", 128'(beats), 128'(d.beats));
            end
            beats = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int b, t0, c0, t_cmd;
      rst = 1'b1;
      req_rd = '0; req_wr = '0;
      req_rd_addr = '0; req_wr_addr = '0; req_rd_len = '0; req_wr_len = '0;
      init_calib_complete = 1'b1;
      for (int i = 0; i < N; i++) req_wr_data[i*DW +: DW] = wd(i);

      // Test 1: stray strobes in IDLE, then a single read burst.
      do_reset();
      @(negedge clk); #1 stray_go = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stray_ignored", {req_rd_data_valid, req_wr_data_req, req_done, grant,
                              mem_rd_burst_req, mem_wr_burst_req}, '0);
      #1 stray_go = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      b = done_cnt;
      c0 = cmd_cnt;
      set_rd(1, 28'h100, 10'd4);
      expect_burst(1'b1, 1, 28'h100, 10'd4, 4);
      req_rd[1] = 1'b1;
      t0 = cyc;
      wait_cmd(c0 + 1);
      check("rd_latency", 128'(last_cmd_cyc), 128'(t0 + 1));
      wait_done(b + 1);
      req_rd[1] = 1'b0;
      @(negedge clk);
      check("grant_cleared", 128'(grant), 0);

      // Test 2: three continuous writers, round-robin order 0,1,2,0,1,2.
      do_reset();
      b = done_cnt;
      for (int i = 0; i < N; i++) set_wr(i, 28'h200 + 28'(i * 16), 10'd2);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++)
            expect_burst(1'b0, i, 28'h200 + 28'(i * 16), 10'd2, 2);
      req_wr = '1;
      wait_done(b + 6);
      req_wr = '0;

      // Test 3: requester 2 asks rd+wr; read first, its write after 0 and 1.
      do_reset();
      b = done_cnt;
      set_rd(2, 28'h300, 10'd3);
      set_wr(2, 28'h380, 10'd3);
      expect_burst(1'b1, 2, 28'h300, 10'd3, 3);
      req_rd[2] = 1'b1;
      req_wr[2] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      set_wr(0, 28'h400, 10'd3);
      set_wr(1, 28'h480, 10'd3);
      expect_burst(1'b0, 0, 28'h400, 10'd3, 3);
      expect_burst(1'b0, 1, 28'h480, 10'd3, 3);
      expect_burst(1'b0, 2, 28'h380, 10'd3, 3);
      req_wr[0] = 1'b1;
      req_wr[1] = 1'b1;
      wait_done(b + 1); req_rd[2] = 1'b0;
      wait_done(b + 2); req_wr[0] = 1'b0;
      wait_done(b + 3); req_wr[1] = 1'b0;
      wait_done(b + 4); req_wr[2] = 1'b0;

      // Test 4: zero-length write completes with no controller command.
      do_reset();
      b = done_cnt;
      c0 = cmd_cnt;
      set_wr(0, 28'h0ABC, 10'd0);
      expect_burst(1'b0, 0, 28'h0ABC, 10'd0, 0);
      req_wr[0] = 1'b1;
      t0 = cyc;
      wait_done(b + 1);
      req_wr[0] = 1'b0;
      check("zero_len_done_cyc", 128'(last_done_cyc), 128'(t0 + 1));
      repeat (3) @(negedge clk);
      check("zero_len_no_cmd", 128'(cmd_cnt), 128'(c0));

      // Test 5: hung burst times out; next requester proceeds; error is sticky.
      do_reset();
      b = done_cnt;
      c0 = cmd_cnt;
      set_rd(0, 28'h500, 10'd5);
      set_rd(1, 28'h580, 10'd2);
      expect_burst(1'b1, 0, 28'h500, 10'd5, 0);
      expect_burst(1'b1, 1, 28'h580, 10'd2, 2);
      ctl_hang = 1'b1;
      req_rd = 3'b011;
      wait_cmd(c0 + 1);
      t_cmd = last_cmd_cyc;
      wait_done(b + 1);
      req_rd[0] = 1'b0;
      ctl_hang = 1'b0;
      check("to_err_cyc", 128'(err_cyc), 128'(t_cmd + TO + 1));
      check("to_done_cyc", 128'(last_done_cyc), 128'(t_cmd + TO + 1));
      wait_done(b + 2);
      req_rd[1] = 1'b0;
      @(negedge clk);
      check("to_sticky", 128'(timeout_err), 1);

      // Test 6: reset mid-BUSY, then arbitration held off by calibration.
      do_reset();
      c0 = cmd_cnt;
      set_rd(0, 28'h600, 10'd8);
      exp_q.push_back('{1'b1, 28'h600, 10'd8, 0});
      ctl_hang = 1'b1;
      req_rd[0] = 1'b1;
      wait_cmd(c0 + 1);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      req_rd = '0;
      @(negedge clk);
      check("mid_rst_outs", {grant, req_done, req_rd_data_valid, req_wr_data_req,
                             mem_rd_burst_req, mem_wr_burst_req, timeout_err}, '0);
      check("mid_rst_fields", {mem_rd_burst_addr, mem_rd_burst_len}, '0);
      #1 init_calib_complete = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      ctl_hang = 1'b0;
      b = done_cnt;
      set_rd(0, 28'h700, 10'd2);
      set_rd(1, 28'h780, 10'd2);
      expect_burst(1'b1, 0, 28'h700, 10'd2, 2);
      expect_burst(1'b1, 1, 28'h780, 10'd2, 2);
      req_rd = 3'b011;
      c0 = cmd_cnt;
      repeat (5) @(negedge clk);
      #1;
      check("calib_hold", 128'(cmd_cnt), 128'(c0));
      init_calib_complete = 1'b1;
      t0 = cyc;
      wait_cmd(c0 + 1);
      check("calib_latency", 128'(last_cmd_cyc), 128'(t0 + 1));
      wait_done(b + 1); req_rd[0] = 1'b0;
      wait_done(b + 2); req_rd[1] = 1'b0;
      repeat (3) @(negedge clk);

      check("exp_q_drained", 128'(exp_q.size()), 0);
      check("done_q_drained", 128'(done_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
